// File: rtl/msi_bus_arbiter.sv
// Snooping-bus controller for the MSI cache array: round-robin grant,
// broadcast, snoop-ack collection, optional Flush cycle and completion pulse.
module msi_bus_arbiter #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CACHES-1:0]         req_i,
  input  logic [2*NUM_CACHES-1:0]       req_msg_i,
  input  logic [ADDR_W*NUM_CACHES-1:0]  req_addr_i,
  input  logic [NUM_CACHES-1:0]         snoop_ack_i,
  input  logic [NUM_CACHES-1:0]         flush_i,
  output logic [NUM_CACHES-1:0]         gnt_o,
  output logic [NUM_CACHES-1:0]         done_o,
  output logic                          bus_valid_o,
  output logic [1:0]                    bus_msg_o,
  output logic [ADDR_W-1:0]             bus_addr_o,
  output logic [$clog2(NUM_CACHES)-1:0] bus_src_o,
  output logic                          err_o
);

  localparam int N  = NUM_CACHES;
  localparam int IW = $clog2(NUM_CACHES);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW:0] NL = (IW+1)'(NUM_CACHES);

  typedef enum logic [2:0] {
    IDLE, GRANT, SNOOP, FLUSH, DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]     ptr, owner, flusher;
  logic [IW-1:0]     pick, fl_pick;
  logic [1:0]        msg, pick_msg;
  logic [ADDR_W-1:0] addr, pick_addr;
  logic [N-1:0]      ack_seen, flush_seen;
  logic [N-1:0]      own_oh, fl;
  logic [CW-1:0]     cnt;
  logic [IW:0]       ptr_nx;
  logic              multi, timed_out;
  logic              any_req, ack_all, any_flush;
  logic              fl_multi, cnt_last;

  // Lowest requester overall, overridden by the lowest at/after the pointer.
  always_comb begin
    pick = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (req_i[i]) pick = IW'(i);
    end
    for (int i = N-1; i >= 0; i--) begin
      if (req_i[i] && IW'(i) >= ptr) pick = IW'(i);
    end
    any_req = |req_i;
  end

  always_comb begin
    pick_msg  = '0;
    pick_addr = '0;
    own_oh    = '0;
    for (int k = 0; k < N; k++) begin
      if (pick == IW'(k)) begin
        pick_msg  = req_msg_i[2*k +: 2];
        pick_addr = req_addr_i[ADDR_W*k +: ADDR_W];
      end
      own_oh[k] = (owner == IW'(k));
    end
  end

  always_comb begin
    fl      = (flush_seen | flush_i) & ~own_oh;
    fl_pick = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (fl[k]) fl_pick = IW'(k);
    end
    any_flush = |fl;
    fl_multi  = |(fl & (fl - N'(1)));
    ack_all   = &(ack_seen | snoop_ack_i | own_oh);
    cnt_last  = (cnt == CW'(TIMEOUT-1));
    ptr_nx    = {1'b0, owner} + (IW+1)'(1);
    if (ptr_nx == NL) ptr_nx = '0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = GRANT;
      GRANT:   state_nx = (msg == 2'b11) ? DONE : SNOOP;
      SNOOP: begin
        if (ack_all)       state_nx = any_flush ? FLUSH : DONE;
        else if (cnt_last) state_nx = DONE;
      end
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      msg        <= '0;
      addr       <= '0;
      ack_seen   <= '0;
      flush_seen <= '0;
      cnt        <= '0;
      flusher    <= '0;
      multi      <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        owner     <= pick;
        msg       <= pick_msg;
        addr      <= pick_addr;
        timed_out <= 1'b0;
      end
      if (state == IDLE || state == DONE) begin
        ack_seen   <= '0;
        flush_seen <= '0;
      end else begin
        ack_seen   <= ack_seen | (snoop_ack_i & ~own_oh);
        flush_seen <= flush_seen | (flush_i & ~own_oh);
      end
      if (state == SNOOP) begin
        cnt       <= cnt + CW'(1);
        flusher   <= fl_pick;
        multi     <= fl_multi;
        timed_out <= !ack_all && cnt_last;
      end else begin
        cnt <= '0;
      end
      if (state == DONE) ptr <= ptr_nx[IW-1:0];
    end
  end

  always_comb begin
    gnt_o       = '0;
    done_o      = '0;
    bus_valid_o = 1'b0;
    bus_msg_o   = '0;
    bus_addr_o  = '0;
    bus_src_o   = '0;
    err_o       = 1'b0;
    unique case (state)
      GRANT: begin
        gnt_o       = own_oh;
        bus_valid_o = 1'b1;
        bus_msg_o   = msg;
        bus_addr_o  = addr;
        bus_src_o   = owner;
      end
      SNOOP: gnt_o = own_oh;
      FLUSH: begin
        gnt_o       = own_oh;
        bus_valid_o = 1'b1;
        bus_msg_o   = 2'b11;
        bus_addr_o  = addr;
        bus_src_o   = flusher;
        err_o       = multi;
      end
      DONE: begin
        gnt_o  = own_oh;
        done_o = own_oh;
        err_o  = timed_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Bench for msi_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level schedule model.
module tb_msi_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int TO = 8;
  localparam int NEVER = 100;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [2*N-1:0] req_msg_i = '0;
  logic [AW*N-1:0] req_addr_i = '0;
  logic [N-1:0]  snoop_ack_i = '0;
  logic [N-1:0]  flush_i = '0;
  logic [N-1:0]  gnt_o, done_o;
  logic          bus_valid_o;
  logic [1:0]    bus_msg_o;
  logic [AW-1:0] bus_addr_o;
  logic [1:0]    bus_src_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  msi_bus_arbiter #(
    .NUM_CACHES(N), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_msg_i(req_msg_i),
    .req_addr_i(req_addr_i),
    .snoop_ack_i(snoop_ack_i), .flush_i(flush_i),
    .gnt_o(gnt_o), .done_o(done_o),
    .bus_valid_o(bus_valid_o), .bus_msg_o(bus_msg_o),
    .bus_addr_o(bus_addr_o), .bus_src_o(bus_src_o),
    .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = 0;
  int ack_t[N];
  int fl_t[N];
  logic [N-1:0] onoise = '0;
  bit scramble = 1'b0;

  function automatic logic [15:0] mk(
    logic [3:0] g, logic [3:0] d, logic v,
    logic [1:0] m, logic [1:0] a, logic [1:0] s, logic e);
    return {g, d, v, m, a, s, e};
  endfunction

  function automatic logic [15:0] obs();
    return {gnt_o, done_o, bus_valid_o, bus_msg_o,
            bus_addr_o, bus_src_o, err_o};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o,
                     input logic [15:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle_cycle(input string tag);
    req_i = '0;
    snoop_ack_i = '0;
    flush_i = '0;
    @(negedge clk_i);
    chk(tag, obs(), '0);
    @(posedge clk_i); #1;
  endtask

  // Schedule per transaction: 0 grant, 1 snoop, 2 flush, 3 done.
  task automatic run_txn(input string tag, input logic [N-1:0] rq,
                         input logic [2*N-1:0] msgs,
                         input logic [AW*N-1:0] addrs);
    int owner, tmax, ns, fcount, flo;
    bit tmo;
    logic [1:0] m, a;
    logic [N-1:0] oh;
    logic [15:0] e;
    int ph[$];
    owner = -1; tmax = 0; fcount = 0; flo = 0; tmo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner < 0 && rq[(mptr + i) % N]) owner = (mptr + i) % N;
    end
    m  = msgs[2*owner +: 2];
    a  = addrs[AW*owner +: AW];
    oh = N'(1) << owner;
    for (int j = 0; j < N; j++) begin
      if (j != owner && ack_t[j] > tmax) tmax = ack_t[j];
    end
    ph.push_back(0);
    if (m == 2'b11) begin
      ph.push_back(3);
    end else if (tmax <= TO) begin
      ns = (tmax < 1) ? 1 : tmax;
      for (int s = 0; s < ns; s++) ph.push_back(1);
      for (int j = N-1; j >= 0; j--) begin
        if (j != owner && fl_t[j] <= ns) begin
          fcount++;
          flo = j;
        end
      end
      if (fcount > 0) ph.push_back(2);
      ph.push_back(3);
    end else begin
      tmo = 1'b1;
      for (int s = 0; s < TO; s++) ph.push_back(1);
      ph.push_back(3);
    end
    req_i = rq; req_msg_i = msgs; req_addr_i = addrs;
    snoop_ack_i = '0; flush_i = '0;
    @(negedge clk_i);
    chk($sformatf("%s idle", tag), obs(), '0);
    @(posedge clk_i); #1;
    for (int t = 0; t < ph.size(); t++) begin
      for (int j = 0; j < N; j++) begin
        snoop_ack_i[j] = (j == owner) ? onoise[j] : (ack_t[j] == t);
        flush_i[j]     = (j == owner) ? onoise[j] : (fl_t[j] == t);
      end
      if (scramble && t > 0) begin
        req_i = N'($urandom);
        req_msg_i = (2*N)'($urandom);
        req_addr_i = (AW*N)'($urandom);
      end
      case (ph[t])
        0:       e = mk(oh, '0, 1'b1, m, a, 2'(owner), 1'b0);
        1:       e = mk(oh, '0, 1'b0, '0, '0, '0, 1'b0);
        2:       e = mk(oh, '0, 1'b1, 2'b11, a, 2'(flo), fcount > 1);
        default: e = mk(oh, oh, 1'b0, '0, '0, '0, tmo);
      endcase
      @(negedge clk_i);
      chk($sformatf("%s own%0d t%0d", tag, owner, t), obs(), e);
      @(posedge clk_i); #1;
    end
    mptr = (owner + 1) % N;
    req_i = '0; snoop_ack_i = '0; flush_i = '0;
  endtask

  initial begin
    onoise = '0;
    scramble = 1'b0;
    #2;
    chk("reset", obs(), '0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle_cycle("idle0");
    idle_cycle("idle1");

    ack_t = '{0, 0, 0, 0};
    fl_t  = '{NEVER, NEVER, NEVER, NEVER};
    for (int k = 0; k < 5; k++) run_txn("rr", 4'b1111, 8'h1B, 8'hE4);

    ack_t = '{0, NEVER, 0, 0};
    run_txn("basic", 4'b0010, 8'h00, 8'h08);
    ack_t = '{0, 0, 0, 0};
    run_txn("ptr2", 4'b1111, 8'h00, 8'h00);

    ack_t = '{NEVER, 0, 1, 0};
    fl_t  = '{NEVER, NEVER, 1, NEVER};
    run_txn("flush", 4'b0001, 8'h01, 8'h03);

    ack_t = '{NEVER, NEVER, NEVER, NEVER};
    fl_t  = '{NEVER, NEVER, NEVER, NEVER};
    run_txn("wback", 4'b1000, 8'hC0, 8'h40);

    ack_t = '{0, NEVER, 0, NEVER};
    run_txn("tmo", 4'b0010, 8'h08, 8'h04);

    ack_t = '{0, 0, 0, 0};
    fl_t  = '{0, NEVER, NEVER, 1};
    onoise = 4'b0100;
    run_txn("mflush", 4'b0100, 8'h00, 8'h20);

    for (int k = 0; k < 60; k++) begin
      for (int j = 0; j < N; j++) begin
        ack_t[j] = ($urandom_range(0, 9) == 0) ? NEVER
                 : int'($urandom_range(0, 8));
        fl_t[j]  = ($urandom_range(0, 2) == 0)
                 ? int'($urandom_range(0, 4)) : NEVER;
      end
      onoise = N'($urandom);
      scramble = 1'($urandom);
      run_txn("rand", 4'($urandom_range(1, 15)),
              8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle("rand_idle");
    end

    onoise = '0;
    scramble = 1'b0;
    ack_t = '{0, 0, 0, 0};
    fl_t  = '{NEVER, NEVER, NEVER, NEVER};
    run_txn("pre_rst", 4'b0001, 8'h00, 8'h00);

    req_i = 4'b0010; req_msg_i = 8'h00; req_addr_i = 8'h00;
    @(negedge clk_i);
    chk("rst idle", obs(), '0);
    @(posedge clk_i); #1;
    flush_i = 4'b1000; snoop_ack_i = 4'b0101;
    @(negedge clk_i);
    chk("rst grant", obs(), mk(4'b0010, '0, 1'b1, '0, '0, 2'd1, 1'b0));
    @(posedge clk_i); #1;
    flush_i = '0; snoop_ack_i = '0;
    @(negedge clk_i);
    chk("rst snoop", obs(), mk(4'b0010, '0, 1'b0, '0, '0, '0, 1'b0));
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk("rst async", obs(), '0);
    @(posedge clk_i); #1;
    chk("rst hold", obs(), '0);
    rst_i = 1'b1;
    mptr = 0;
    run_txn("post_rst", 4'b0101, 8'h00, 8'h00);
    run_txn("post_rst2", 4'b0100, 8'h00, 8'h30);
    idle_cycle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
